// File: rtl/wb_write_arbiter_if.sv
// Bus bundle for wb_write_arbiter: ALU/LSU result inputs, issue/decode scoreboard signals and
// the register-file write port. WB_BYPASS_EN adds the same-cycle forwarding outputs.
interface wb_write_arbiter_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        reg_wr_en;
    logic [4:0]  rd;
    logic [31:0] rd_data;
`ifdef WB_BYPASS_EN
    logic        rs1_fwd_valid;
    logic        rs2_fwd_valid;
    logic [31:0] rs1_fwd_data;
    logic [31:0] rs2_fwd_data;
`endif

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
               issue_valid, issue_rd, rs1, rs2,
        input  alu_stall, lsu_ready, rs1_busy, rs2_busy, reg_wr_en, rd, rd_data
`ifdef WB_BYPASS_EN
        , input rs1_fwd_valid, rs2_fwd_valid, rs1_fwd_data, rs2_fwd_data
`endif
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
               issue_valid, issue_rd, rs1, rs2,
        output alu_stall, lsu_ready, rs1_busy, rs2_busy, reg_wr_en, rd, rd_data
`ifdef WB_BYPASS_EN
        , output rs1_fwd_valid, rs2_fwd_valid, rs1_fwd_data, rs2_fwd_data
`endif
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: ALU results bypass a small long-latency result FIFO, with
// an anti-starvation stall and a pending scoreboard. Optional macro WB_BYPASS_EN adds forwarding.
module wb_write_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input logic                clk,
    input logic                rst_n,
    wb_write_arbiter_if.slave  wb
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {SEL_NONE, SEL_ALU, SEL_FIFO} sel_e;

    wb_entry_t     fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [CW-1:0] starve_q, starve_d;
    logic [31:0]   pending_q, pending_d;
    logic          reg_wr_en_q;
    logic [4:0]    rd_q;
    logic [31:0]   rd_data_q;

    logic          empty, full, push, pop, stall;
    sel_e          sel;
    wb_entry_t     sel_entry;
    logic [31:0]   set_mask, clr_mask;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign push  = wb.lsu_valid && !full;
    assign stall = (starve_q == CW'(STARVE_MAX)) && !empty;
    assign pop   = (sel == SEL_FIFO);

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        sel       = SEL_NONE;
        sel_entry = '0;
        if (stall) begin
            sel       = SEL_FIFO;
            sel_entry = fifo_mem[rd_ptr_q];
        end else if (wb.alu_valid) begin
            sel       = SEL_ALU;
            sel_entry = '{rd: wb.alu_rd, data: wb.alu_data};
        end else if (!empty) begin
            sel       = SEL_FIFO;
            sel_entry = fifo_mem[rd_ptr_q];
        end
    end

    always_comb begin
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
        starve_d = (empty || pop) ? '0 : starve_q + CW'(1);
        set_mask = (wb.issue_valid && wb.issue_rd != 5'd0) ? (32'd1 << wb.issue_rd) : 32'd0;
        clr_mask = reg_wr_en_q ? (32'd1 << rd_q) : 32'd0;
        // A new issue to a register being written this cycle must stay pending.
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    // NOTE: the FIFO storage has no reset; count and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= '{rd: wb.lsu_rd, data: wb.lsu_data};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            pending_q   <= '0;
            reg_wr_en_q <= 1'b0;
            rd_q        <= '0;
            rd_data_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q   <= count_d;
            starve_q  <= starve_d;
            pending_q <= pending_d;
            if (sel == SEL_NONE) begin
                reg_wr_en_q <= 1'b0;
            end else begin
                reg_wr_en_q <= (sel_entry.rd != 5'd0);
                rd_q        <= sel_entry.rd;
                rd_data_q   <= sel_entry.data;
            end
        end
    end

    assign wb.alu_stall = stall;
    assign wb.lsu_ready = !full;
    assign wb.rs1_busy  = pending_q[wb.rs1];
    assign wb.rs2_busy  = pending_q[wb.rs2];
    assign wb.reg_wr_en = reg_wr_en_q;
    assign wb.rd        = rd_q;
    assign wb.rd_data   = rd_data_q;

`ifdef WB_BYPASS_EN
    assign wb.rs1_fwd_valid = reg_wr_en_q && (rd_q == wb.rs1) && (wb.rs1 != 5'd0);
    assign wb.rs2_fwd_valid = reg_wr_en_q && (rd_q == wb.rs2) && (wb.rs2 != 5'd0);
    assign wb.rs1_fwd_data  = rd_data_q;
    assign wb.rs2_fwd_data  = rd_data_q;
`endif
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: ALU path, LSU latency and scoreboard, FIFO starvation,
// rd==0 drops, set/clear collision and mid-operation reset.
module tb_wb_write_arbiter;
    logic clk;
    logic rst_n;
    int   assertions;
    int   failures;

    wb_write_arbiter_if bus ();

    wb_write_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required end of test earlier");
        $fatal(1, "watchdog");
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = '0;
        bus.alu_data    = '0;
        bus.lsu_valid   = 1'b0;
        bus.lsu_rd      = '0;
        bus.lsu_data    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        bus.rs1 = 5'd0;
        bus.rs2 = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        assertions++;
        if (bus.reg_wr_en !== 1'b0 || bus.rd !== 5'd0 || bus.rd_data !== 32'd0) begin
            $display("FAIL reset_outputs: got en=%0b rd=%0d data=%h, expected 0/0/0", bus.reg_wr_en, bus.rd, bus.rd_data);
            failures++;
        end
        assertions++;
        if (bus.lsu_ready !== 1'b1 || bus.alu_stall !== 1'b0 || bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
            $display("FAIL reset_status: got ready=%0b stall=%0b busy=%0b%0b, expected 1/0/00", bus.lsu_ready, bus.alu_stall, bus.rs1_busy, bus.rs2_busy);
            failures++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_alu_write();
        next();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 32'hDEADBEEF;
        #1;
        next();
        idle();
        #1;
        assertions++;
        if (bus.reg_wr_en !== 1'b1 || bus.rd !== 5'd5 || bus.rd_data !== 32'hDEADBEEF) begin
            $display("FAIL alu_write: got en=%0b rd=%0d data=%h, expected 1/5/deadbeef", bus.reg_wr_en, bus.rd, bus.rd_data);
            failures++;
        end
        next();
        assertions++;
        if (bus.reg_wr_en !== 1'b0 || bus.rd !== 5'd5) begin
            $display("FAIL alu_write_done: got en=%0b rd=%0d, expected 0/5", bus.reg_wr_en, bus.rd);
            failures++;
        end
    endtask

    task automatic test_lsu_scoreboard();
        next();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        bus.rs1         = 5'd7;
        #1;
        assertions++;
        if (bus.rs1_busy !== 1'b0) begin
            $display("FAIL lsu_busy_c0: got %0b expected 0", bus.rs1_busy);
            failures++;
        end
        next();
        bus.issue_valid = 1'b0;
        #1;
        assertions++;
        if (bus.rs1_busy !== 1'b1) begin
            $display("FAIL lsu_busy_c1: got %0b expected 1", bus.rs1_busy);
            failures++;
        end
        next();
        next();
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd7;
        bus.lsu_data  = 32'h1234;
        #1;
        assertions++;
        if (bus.lsu_ready !== 1'b1) begin
            $display("FAIL lsu_ready_accept: got %0b expected 1", bus.lsu_ready);
            failures++;
        end
        next();
        bus.lsu_valid = 1'b0;
        #1;
        assertions++;
        if (bus.reg_wr_en !== 1'b0 || bus.rs1_busy !== 1'b1) begin
            $display("FAIL lsu_no_fallthrough: got en=%0b busy=%0b, expected 0/1", bus.reg_wr_en, bus.rs1_busy);
            failures++;
        end
        next();
        assertions++;
        if (bus.reg_wr_en !== 1'b1 || bus.rd !== 5'd7 || bus.rd_data !== 32'h1234 || bus.rs1_busy !== 1'b1) begin
            $display("FAIL lsu_write: got en=%0b rd=%0d data=%h busy=%0b, expected 1/7/1234/1", bus.reg_wr_en, bus.rd, bus.rd_data, bus.rs1_busy);
            failures++;
        end
        next();
        assertions++;
        if (bus.rs1_busy !== 1'b0 || bus.reg_wr_en !== 1'b0) begin
            $display("FAIL lsu_busy_clear: got busy=%0b en=%0b, expected 0/0", bus.rs1_busy, bus.reg_wr_en);
            failures++;
        end
    endtask

    task automatic test_starvation();
        logic        exp_ready, exp_stall, exp_en;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        for (int i = 0; i < 16; i++) begin
            next();
            bus.alu_valid = (i <= 10);
            bus.alu_rd    = 5'd10;
            bus.alu_data  = 32'hA000_0000 + ((i > 9) ? 9 : i);
            bus.lsu_valid = (i <= 9);
            bus.lsu_rd    = (i < 4) ? 5'(11 + i) : 5'd15;
            bus.lsu_data  = (i < 4) ? 32'hB0 + i : 32'hBF;
            #1;
            exp_ready = (i < 4) || (i >= 10);
            exp_stall = (i == 9);
            exp_en    = 1'b1;
            exp_rd    = 5'd10;
            exp_data  = 32'hA000_0000 + i - 1;
            if (i == 0 || i == 15) exp_en = 1'b0;
            else if (i == 10) begin exp_rd = 5'd11; exp_data = 32'hB0; end
            else if (i == 11) begin exp_rd = 5'd10; exp_data = 32'hA000_0009; end
            else if (i >= 12) begin exp_rd = 5'(i); exp_data = 32'hB0 + i - 11; end
            assertions++;
            if (bus.lsu_ready !== exp_ready) begin
                $display("FAIL starve_ready[%0d]: got %0b expected %0b", i, bus.lsu_ready, exp_ready);
                failures++;
            end
            assertions++;
            if (bus.alu_stall !== exp_stall) begin
                $display("FAIL starve_stall[%0d]: got %0b expected %0b", i, bus.alu_stall, exp_stall);
                failures++;
            end
            assertions++;
            if (bus.reg_wr_en !== exp_en || (exp_en && (bus.rd !== exp_rd || bus.rd_data !== exp_data))) begin
                $display("FAIL starve_write[%0d]: got en=%0b rd=%0d data=%h, expected %0b/%0d/%h", i, bus.reg_wr_en, bus.rd, bus.rd_data, exp_en, exp_rd, exp_data);
                failures++;
            end
        end
        idle();
    endtask

    task automatic test_rd_zero();
        next();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd0;
        bus.alu_data  = 32'hFFFFFFFF;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd0;
        bus.lsu_data  = 32'h55;
        #1;
        next();
        idle();
        #1;
        assertions++;
        if (bus.reg_wr_en !== 1'b0) begin
            $display("FAIL rd0_alu: got en=%0b expected 0", bus.reg_wr_en);
            failures++;
        end
        next();
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd9;
        bus.lsu_data  = 32'h99;
        #1;
        assertions++;
        if (bus.reg_wr_en !== 1'b0 || bus.lsu_ready !== 1'b1) begin
            $display("FAIL rd0_fifo: got en=%0b ready=%0b, expected 0/1", bus.reg_wr_en, bus.lsu_ready);
            failures++;
        end
        next();
        idle();
        #1;
        assertions++;
        if (bus.reg_wr_en !== 1'b0) begin
            $display("FAIL rd0_empty_after_pop: got en=%0b expected 0", bus.reg_wr_en);
            failures++;
        end
        next();
        assertions++;
        if (bus.reg_wr_en !== 1'b1 || bus.rd !== 5'd9 || bus.rd_data !== 32'h99) begin
            $display("FAIL rd0_next_entry: got en=%0b rd=%0d data=%h, expected 1/9/99", bus.reg_wr_en, bus.rd, bus.rd_data);
            failures++;
        end
        next();
        assertions++;
        if (bus.reg_wr_en !== 1'b0) begin
            $display("FAIL rd0_drained: got en=%0b expected 0", bus.reg_wr_en);
            failures++;
        end
    endtask

    task automatic test_set_clear_collision();
        next();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd3;
        bus.alu_data  = 32'h33;
        #1;
        next();
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd3;
        bus.rs2         = 5'd3;
        #1;
        assertions++;
        if (bus.reg_wr_en !== 1'b1 || bus.rd !== 5'd3 || bus.rs2_busy !== 1'b0) begin
            $display("FAIL collide_setup: got en=%0b rd=%0d busy=%0b, expected 1/3/0", bus.reg_wr_en, bus.rd, bus.rs2_busy);
            failures++;
        end
        next();
        bus.issue_rd = 5'd0;
        bus.rs1      = 5'd0;
        #1;
        assertions++;
        if (bus.rs2_busy !== 1'b1) begin
            $display("FAIL collide_set_wins: got %0b expected 1", bus.rs2_busy);
            failures++;
        end
        next();
        idle();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd3;
        bus.alu_data  = 32'h3333;
        #1;
        assertions++;
        if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b1) begin
            $display("FAIL collide_bit0: got busy=%0b%0b, expected 01", bus.rs1_busy, bus.rs2_busy);
            failures++;
        end
        next();
        idle();
        #1;
        assertions++;
        if (bus.reg_wr_en !== 1'b1 || bus.rs2_busy !== 1'b1) begin
            $display("FAIL collide_alu_write: got en=%0b busy=%0b, expected 1/1", bus.reg_wr_en, bus.rs2_busy);
            failures++;
        end
        next();
        assertions++;
        if (bus.rs2_busy !== 1'b0) begin
            $display("FAIL collide_alu_clears: got %0b expected 0", bus.rs2_busy);
            failures++;
        end
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        next();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd9;
        bus.alu_data  = 32'h9999;
        bus.rs1       = 5'd9;
        bus.rs2       = 5'd0;
        #1;
        next();
        idle();
        #1;
        assertions++;
        if (bus.rs1_fwd_valid !== 1'b1 || bus.rs1_fwd_data !== 32'h9999 || bus.rs2_fwd_valid !== 1'b0) begin
            $display("FAIL bypass_fwd: got v1=%0b d1=%h v2=%0b, expected 1/9999/0", bus.rs1_fwd_valid, bus.rs1_fwd_data, bus.rs2_fwd_valid);
            failures++;
        end
        next();
        assertions++;
        if (bus.rs1_fwd_valid !== 1'b0) begin
            $display("FAIL bypass_idle: got %0b expected 0", bus.rs1_fwd_valid);
            failures++;
        end
    endtask
`endif

    task automatic test_reset_mid_op();
        for (int i = 0; i < 3; i++) begin
            next();
            bus.alu_valid   = 1'b1;
            bus.alu_rd      = 5'd10;
            bus.alu_data    = 32'hC0 + i;
            bus.lsu_valid   = 1'b1;
            bus.lsu_rd      = 5'(21 + i);
            bus.lsu_data    = 32'hD0 + i;
            bus.issue_valid = (i < 2);
            bus.issue_rd    = 5'(4 + i);
            bus.rs1         = 5'd4;
            bus.rs2         = 5'd5;
            #1;
        end
        next();
        bus.lsu_valid   = 1'b0;
        bus.issue_valid = 1'b0;
        #1;
        assertions++;
        if (bus.rs1_busy !== 1'b1 || bus.rs2_busy !== 1'b1 || bus.reg_wr_en !== 1'b1) begin
            $display("FAIL midrst_setup: got busy=%0b%0b en=%0b, expected 11/1", bus.rs1_busy, bus.rs2_busy, bus.reg_wr_en);
            failures++;
        end
        rst_n = 1'b0;
        idle();
        #1;
        assertions++;
        if (bus.reg_wr_en !== 1'b0 || bus.lsu_ready !== 1'b1 || bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0 || bus.rd !== 5'd0) begin
            $display("FAIL midrst_async: got en=%0b ready=%0b busy=%0b%0b rd=%0d, expected 0/1/00/0", bus.reg_wr_en, bus.lsu_ready, bus.rs1_busy, bus.rs2_busy, bus.rd);
            failures++;
        end
        repeat (2) next();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            next();
            assertions++;
            if (bus.reg_wr_en !== 1'b0) begin
                $display("FAIL midrst_quiet[%0d]: got en=%0b expected 0", i, bus.reg_wr_en);
                failures++;
            end
        end
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd6;
        bus.lsu_data  = 32'h66;
        next();
        idle();
        next();
        assertions++;
        if (bus.reg_wr_en !== 1'b1 || bus.rd !== 5'd6 || bus.rd_data !== 32'h66) begin
            $display("FAIL midrst_fresh: got en=%0b rd=%0d data=%h, expected 1/6/66", bus.reg_wr_en, bus.rd, bus.rd_data);
            failures++;
        end
    endtask

    initial begin
        assertions = 0;
        failures   = 0;
        test_reset();
        test_alu_write();
        test_lsu_scoreboard();
        test_starvation();
        test_rd_zero();
        test_set_clear_collision();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Write-side front end for the 32x32 integer register file; the register file's single write port is driven by this block.
- Merges single-cycle ALU results with long-latency LSU/divider results, buffered in a small FIFO.
- Keeps a 32-entry pending scoreboard so decode can stall on registers whose long-latency result has not yet been written.

Parameters:
- DEPTH, 4, LSU result FIFO entries; power of 2, >=2.
- STARVE_MAX, 8, max consecutive cycles a non-empty FIFO may be bypassed by ALU writes before the ALU is stalled.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  async active-low reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- alu_stall  out  1  upstream must hold ALU result; block ignores ALU this cycle.
- lsu_valid  in  1  long-latency result offered.
- lsu_ready  out  1  FIFO can accept.
- lsu_rd  in  5  long-latency destination register.
- lsu_data  in  32  long-latency result.
- issue_valid  in  1  long-latency op issued this cycle.
- issue_rd  in  5  destination register of the issued op.
- rs1  in  5  decode source 1.
- rs2  in  5  decode source 2.
- rs1_busy  out  1  rs1 pending.
- rs2_busy  out  1  rs2 pending.
- reg_wr_en  out  1  register file write enable, registered.
- rd  out  5  register file write address, registered.
- rd_data  out  32  register file write data, registered.

Behaviour:
- Reset (async, rst_n low):
  - reg_wr_en/rd/rd_data = 0.
  - FIFO empty; scoreboard all 0; starve counter 0.
  - Hence lsu_ready = 1, alu_stall = 0, rs*_busy = 0.
- lsu_ready = !full, computed from the current count. No push when full, even if a pop occurs in the same cycle.
- Push when lsu_valid && lsu_ready. The FIFO stores {rd, data} and wraps modulo DEPTH.
- Per-cycle selection, highest priority first:
  - (a) alu_stall high -> pop FIFO head.
  - (b) alu_valid -> ALU result.
  - (c) FIFO non-empty -> pop head.
  - (d) nothing.
- The selected result is registered into rd/rd_data at the next edge; reg_wr_en is set at that edge only if the selected rd != 0.
  - rd == 0 results are dropped silently; the FIFO still pops.
  - With (d) selected, reg_wr_en = 0 and rd/rd_data hold their values.
- Latency:
  - ALU: valid in cycle N -> reg_wr_en high in cycle N+1.
  - LSU: accepted in cycle N -> earliest reg_wr_en in cycle N+2. There is no push-to-output fall-through.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and not popped.
  - Resets to 0 on any pop or when the FIFO is empty.
  - alu_stall = (cnt == STARVE_MAX) && !empty, combinational from the registered counter.
- Scoreboard, pending[31:0]:
  - Set on issue_valid && issue_rd != 0.
  - Cleared at the clock edge ending a cycle in which reg_wr_en = 1 for rd = that register. This applies to either source; an ALU write also clears.
  - When set and clear hit the same register in the same cycle, set wins.
  - Bit 0 is never set.
- rs1_busy = pending[rs1]; rs2_busy = pending[rs2]; both combinational. Busy drops in the cycle after the register file write edge, so decode then reads the updated value.
- Reset mid-operation: FIFO contents and pending bits are discarded; no write is issued after rst_n deasserts until new input arrives.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: adds ports rs1_fwd_valid/rs2_fwd_valid (out, 1) and rs1_fwd_data/rs2_fwd_data (out, 32).
  - rsX_fwd_valid = reg_wr_en && rd == rsX && rsX != 0; rsX_fwd_data = rd_data.
  - Combinational, so decode can use the value being written this cycle.
  - rsX_busy is unchanged by this feature.
- Undefined: these ports do not exist, and decode must wait one cycle after the write.

Test Plan:
1. alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF in cycle 0 -> cycle 1: reg_wr_en=1, rd=5, rd_data=0xDEADBEEF; cycle 2: reg_wr_en=0.
2. issue_valid rd=7; three cycles later LSU push rd=7 data=0x1234, ALU idle -> rs1=7 gives rs1_busy=1 until the write; reg_wr_en/rd=7/0x1234 appear 2 cycles after accept; rs1_busy=0 the following cycle.
3. Fill the FIFO with 4 LSU pushes while alu_valid is held high -> lsu_ready=0 after the 4th push. After 8 bypassed cycles, alu_stall=1 for one cycle and the FIFO head is written; the held ALU result is written the cycle after.
4. alu_rd=0 data=0xFFFFFFFF, and FIFO entry rd=0 -> reg_wr_en stays 0; the FIFO count decrements.
5. Same-cycle issue_valid rd=3 while reg_wr_en writes rd=3 -> pending[3] remains 1 and rs2=3 gives rs2_busy=1.
6. Assert rst_n=0 with 3 FIFO entries and pending bits set -> immediately reg_wr_en=0, lsu_ready=1, busy=0; no writes after release.
